// File: rtl/rpn_pkg.sv
// rpn_pkg: opcodes, error codes, FSM states and operand-count rules for the RPN stack ALU
package rpn_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_PUSH = 4'd1,
    OP_DROP = 4'd2,
    OP_DUP  = 4'd3,
    OP_SWAP = 4'd4,
    OP_NEG  = 4'd5,
    OP_ADD  = 4'd6,
    OP_SUB  = 4'd7,
    OP_MUL  = 4'd8
  } op_t;
  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_UNDER = 2'd1;
  localparam logic [1:0] E_OVER  = 2'd2;
  localparam logic [1:0] E_ILL   = 2'd3;
  typedef enum logic {S_IDLE, S_MUL} state_t;
  function automatic logic [1:0] min_cnt(input logic [3:0] op);
    case (op)
      OP_DROP, OP_DUP, OP_NEG:          min_cnt = 2'd1;
      OP_SWAP, OP_ADD, OP_SUB, OP_MUL:  min_cnt = 2'd2;
      default:                          min_cnt = 2'd0;
    endcase
  endfunction
  function automatic logic needs_room(input logic [3:0] op);
    needs_room = (op == OP_PUSH) || (op == OP_DUP);
  endfunction
endpackage

// File: rtl/rpn_stack_alu_if.sv
// rpn_stack_alu_if: command handshake and stack readout bundle
interface rpn_stack_alu_if #(parameter int N = 16, parameter int M = 10);
  logic         op_valid;
  logic         op_ready;
  logic [3:0]   op;
  logic [N-1:0] d;
  logic [N-1:0] top;
  logic [M:0]   cnt;
  logic         empty;
  logic         full;
  logic         err;
  logic [1:0]   err_code;
  modport master (output op_valid, op, d, input op_ready, top, cnt, empty, full, err, err_code);
  modport slave  (input op_valid, op, d, output op_ready, top, cnt, empty, full, err, err_code);
endinterface

// File: rtl/stack_ram.sv
// stack_ram: 2**M x N storage, asynchronous read, synchronous write
module stack_ram #(parameter int N = 16, parameter int M = 10) (
  input  logic         clk,
  input  logic         we,
  input  logic [M-1:0] waddr,
  input  logic [M-1:0] raddr,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata
);
  logic [N-1:0] mem [2**M];
  // write port
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/rpn_stack_alu.sv
// rpn_stack_alu: RPN stack calculator with error reporting and shift-add multiplier
module rpn_stack_alu import rpn_pkg::*; #(parameter int N = 16, parameter int M = 10) (
  input logic clk,
  input logic rst,
  rpn_stack_alu_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [M:0] CAP = (M+1)'(2**M);
  localparam logic [M:0] ONE = (M+1)'(1);
  localparam logic [SW-1:0] LAST = SW'(N-1);
  state_t state, state_nx;
  logic [N-1:0] top_r, top_nx, s, wdata, mcand, mplier, acc, acc_nx;
  logic [M:0] cnt_r, cnt_nx;
  logic [M-1:0] a1, a2, waddr;
  logic [SW-1:0] step;
  logic [1:0] ecode, err_code_r;
  logic err_r, accept, illegal, under, over, bad, ok, we, full;
  // a1/a2 address elements cnt-1 and cnt-2; wrapping at cnt==2**M still lands on the last slot
  assign a1 = cnt_r[M-1:0] - M'(1);
  assign a2 = cnt_r[M-1:0] - M'(2);
  assign full = cnt_r == CAP;
  assign accept = bus.op_valid && state == S_IDLE;
  assign illegal = bus.op > OP_MUL;
  assign under = cnt_r < (M+1)'(min_cnt(bus.op));
  assign over = needs_room(bus.op) && full;
  assign bad = illegal || under || over;
  assign ok = accept && !bad;
  assign ecode = illegal ? E_ILL : under ? E_UNDER : E_OVER;
  assign acc_nx = acc + (mplier[0] ? mcand : '0);
  stack_ram #(.N(N), .M(M)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .raddr(a2), .wdata(wdata), .rdata(s)
  );
  // next-state, stack update and RAM write decode
  always_comb begin
    state_nx = state;
    top_nx = top_r;
    cnt_nx = cnt_r;
    we = 1'b0;
    waddr = a1;
    wdata = top_r;
    if (state == S_MUL) begin
      if (step == LAST) begin
        state_nx = S_IDLE;
        top_nx = acc_nx;
        cnt_nx = cnt_r - ONE;
      end
    end else if (ok) begin
      case (bus.op)
        OP_PUSH: begin we = cnt_r != '0; top_nx = bus.d; cnt_nx = cnt_r + ONE; end
        OP_DROP: begin top_nx = cnt_r >= (M+1)'(2) ? s : '0; cnt_nx = cnt_r - ONE; end
        OP_DUP:  begin we = 1'b1; cnt_nx = cnt_r + ONE; end
        OP_SWAP: begin we = 1'b1; waddr = a2; top_nx = s; end
        OP_NEG:  top_nx = '0 - top_r;
        OP_ADD:  begin top_nx = s + top_r; cnt_nx = cnt_r - ONE; end
        OP_SUB:  begin top_nx = s - top_r; cnt_nx = cnt_r - ONE; end
        OP_MUL:  state_nx = S_MUL;
        default: ;
      endcase
    end
  end
  // state, stack registers and sticky error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      top_r <= '0;
      cnt_r <= '0;
      err_r <= 1'b0;
      err_code_r <= E_NONE;
    end else begin
      state <= state_nx;
      top_r <= top_nx;
      cnt_r <= cnt_nx;
      if (accept && bad) begin
        err_r <= 1'b1;
        err_code_r <= ecode;
      end
    end
  // shift-add multiplier datapath
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      step <= '0;
    end else if (state == S_IDLE) begin
      if (ok && bus.op == OP_MUL) begin
        mcand <= s;
        mplier <= top_r;
        acc <= '0;
        step <= '0;
      end
    end else begin
      acc <= acc_nx;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      step <= step + SW'(1);
    end
  assign bus.op_ready = state == S_IDLE;
  assign bus.top = top_r;
  assign bus.cnt = cnt_r;
  assign bus.empty = cnt_r == '0;
  assign bus.full = full;
  assign bus.err = err_r;
  assign bus.err_code = err_code_r;
endmodule

// File: tb/tb_rpn_stack_alu.sv
// tb_rpn_stack_alu: queue-model checked random and directed tests of the RPN stack ALU
module tb_rpn_stack_alu;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  rpn_stack_alu_if #(.N(16), .M(10)) b0 ();
  rpn_stack_alu_if #(.N(16), .M(2)) b1 ();
  rpn_stack_alu #(.N(16), .M(10)) u0 (.clk(clk), .rst(rst), .bus(b0));
  rpn_stack_alu #(.N(16), .M(2)) u1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  logic [15:0] mq[$];
  int m_busy = 0;
  bit m_acc = 0;
  bit m_err = 0;
  int m_code = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask
  task automatic m_error(input int c);
    m_err = 1;
    m_code = c;
  endtask
  task automatic model_op(input logic [3:0] o, input logic [15:0] v);
    int n;
    int need;
    bit room;
    logic [15:0] a, b;
    n = mq.size();
    need = (o inside {4'd2, 4'd3, 4'd5}) ? 1 : (o inside {[4'd4:4'd4], [4'd6:4'd8]}) ? 2 : 0;
    room = o inside {4'd1, 4'd3};
    if (o > 4'd8) m_error(3);
    else if (n < need) m_error(1);
    else if (room && n == 1024) m_error(2);
    else
      case (o)
        4'd1: mq.push_back(v);
        4'd2: void'(mq.pop_back());
        4'd3: mq.push_back(mq[n-1]);
        4'd4: begin a = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = a; end
        4'd5: mq[n-1] = 16'd0 - mq[n-1];
        4'd6: begin b = mq.pop_back(); a = mq.pop_back(); mq.push_back(a + b); end
        4'd7: begin b = mq.pop_back(); a = mq.pop_back(); mq.push_back(a - b); end
        4'd8: m_busy = 16;
        default: ;
      endcase
  endtask
  // reference model advances on every clock edge, resets asynchronously
  always @(posedge clk or posedge rst) begin
    logic [15:0] a, b;
    m_acc = 0;
    if (rst) begin
      mq.delete();
      m_busy = 0;
      m_err = 0;
      m_code = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        b = mq.pop_back();
        a = mq.pop_back();
        mq.push_back(16'((32'(a) * 32'(b)) & 32'hffff));
      end
    end else if (b0.op_valid === 1'b1) begin
      m_acc = 1;
      model_op(b0.op, b0.d);
    end
  end
  // compare the M=10 instance against the model mid-cycle
  always @(negedge clk) begin
    chk("top", 32'(b0.top), mq.size() > 0 ? 32'(mq[mq.size()-1]) : 0);
    chk("cnt", 32'(b0.cnt), 32'(mq.size()));
    chk("empty", 32'(b0.empty), 32'(mq.size() == 0));
    chk("full", 32'(b0.full), 32'(mq.size() == 1024));
    chk("op_ready", 32'(b0.op_ready), 32'(m_busy == 0));
    chk("err", 32'(b0.err), 32'(m_err));
    chk("err_code", 32'(b0.err_code), 32'(m_code));
  end
  task automatic cmd(input logic [3:0] o, input logic [15:0] v);
    int n = 0;
    b0.op_valid = 1'b1;
    b0.op = o;
    b0.d = v;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 40);
    chk("accept_in_budget", 32'(m_acc), 1);
    b0.op_valid = 1'b0;
  endtask
  task automatic cmd1(input logic [3:0] o, input logic [15:0] v);
    b1.op_valid = 1'b1;
    b1.op = o;
    b1.d = v;
    @(posedge clk);
    #1;
    b1.op_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    int n;
    rst = 1'b1;
    b0.op_valid = 1'b0; b0.op = 4'd0; b0.d = 16'd0;
    b1.op_valid = 1'b0; b1.op = 4'd0; b1.d = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_top", 32'(b0.top), 0);
    chk("rst_ready", 32'(b0.op_ready), 1);
    rst = 1'b0;
    chk("m2_empty", 32'(b1.empty), 1);
    for (int i = 1; i <= 4; i++) cmd1(4'd1, 16'(i));
    chk("m2_full", 32'(b1.full), 1);
    cmd1(4'd1, 16'd9);
    chk("m2_push_over_code", 32'(b1.err_code), 2);
    chk("m2_push_over_top", 32'(b1.top), 4);
    chk("m2_push_over_cnt", 32'(b1.cnt), 4);
    cmd1(4'd13, 16'd0);
    chk("m2_illegal_code", 32'(b1.err_code), 3);
    cmd1(4'd3, 16'd0);
    chk("m2_dup_over_code", 32'(b1.err_code), 2);
    chk("m2_dup_over_cnt", 32'(b1.cnt), 4);
    cmd(4'd1, 16'd3); cmd(4'd1, 16'd4); cmd(4'd6, 16'd0);
    chk("add_top", 32'(b0.top), 7);
    chk("add_cnt", 32'(b0.cnt), 1);
    chk("add_err", 32'(b0.err), 0);
    do_reset();
    cmd(4'd1, 16'd10); cmd(4'd1, 16'd3); cmd(4'd7, 16'd0);
    chk("sub_top", 32'(b0.top), 7);
    cmd(4'd1, 16'd5); cmd(4'd4, 16'd0);
    chk("swap_top", 32'(b0.top), 7);
    chk("swap_cnt", 32'(b0.cnt), 2);
    cmd(4'd2, 16'd0);
    chk("swap_second", 32'(b0.top), 5);
    do_reset();
    cmd(4'd1, 16'd300); cmd(4'd1, 16'd300); cmd(4'd8, 16'd0);
    b0.op_valid = 1'b1; b0.op = 4'd1; b0.d = 16'd2;
    n = 0;
    while (b0.op_ready !== 1'b1 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("mul_busy_cycles", 32'(n), 16);
    chk("mul_top", 32'(b0.top), 24464);
    chk("mul_cnt", 32'(b0.cnt), 1);
    @(posedge clk);
    #1;
    b0.op_valid = 1'b0;
    chk("held_push_top", 32'(b0.top), 2);
    chk("held_push_cnt", 32'(b0.cnt), 2);
    do_reset();
    cmd(4'd6, 16'd0);
    chk("under_err", 32'(b0.err), 1);
    chk("under_code", 32'(b0.err_code), 1);
    chk("under_cnt", 32'(b0.cnt), 0);
    chk("under_top", 32'(b0.top), 0);
    cmd(4'd12, 16'd0);
    chk("illegal_code", 32'(b0.err_code), 3);
    do_reset();
    cmd(4'd1, 16'd5); cmd(4'd1, 16'd6); cmd(4'd8, 16'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_top", 32'(b0.top), 0);
    chk("abort_cnt", 32'(b0.cnt), 0);
    chk("abort_ready", 32'(b0.op_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd(4'd1, 16'd1);
    chk("post_abort_top", 32'(b0.top), 1);
    chk("post_abort_cnt", 32'(b0.cnt), 1);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] o;
      r = int'($urandom_range(0, 99));
      o = r < 35 ? 4'd1 : r < 95 ? 4'(r % 9) : 4'($urandom_range(9, 15));
      cmd(o, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
